// File: rtl/burst_mem_arbiter_n.sv
// N-channel burst memory arbiter: zero-latency start, grant held until out_burst_done, beat-count checking.
// Optional: define ROUND_ROBIN_EN for rotating idle priority (default is fixed priority, lowest index wins).
module burst_mem_arbiter_n #(
    parameter int NUM_CHANNELS    = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_LEN_WIDTH = 8
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [NUM_CHANNELS-1:0]                 in_rd,
    input  logic [NUM_CHANNELS-1:0]                 in_wr,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]      in_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]      in_din,
    input  logic [NUM_CHANNELS*(DATA_WIDTH/8)-1:0]  in_mask,
    input  logic [NUM_CHANNELS*BURST_LEN_WIDTH-1:0] in_burst_len,
    output logic [DATA_WIDTH-1:0]                   in_dout,
    output logic [NUM_CHANNELS-1:0]                 in_wait_n,
    output logic [NUM_CHANNELS-1:0]                 in_valid,
    output logic [NUM_CHANNELS-1:0]                 in_burst_done,
    output logic                                    out_rd,
    output logic                                    out_wr,
    output logic [ADDR_WIDTH-1:0]                   out_addr,
    output logic [DATA_WIDTH/8-1:0]                 out_mask,
    output logic [DATA_WIDTH-1:0]                   out_din,
    output logic [BURST_LEN_WIDTH-1:0]              out_burst_len,
    input  logic [DATA_WIDTH-1:0]                   out_dout,
    input  logic                                    out_wait_n,
    input  logic                                    out_valid,
    input  logic                                    out_burst_done,
    output logic                                    busy,
    output logic [NUM_CHANNELS-1:0]                 grant,
    output logic                                    protocol_error
);
    localparam int N  = NUM_CHANNELS;
    localparam int MW = DATA_WIDTH / 8;
    localparam int LW = BURST_LEN_WIDTH;
    localparam int CW = BURST_LEN_WIDTH + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  grant_q, grant_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic          perr_q, perr_nxt;
    logic          lat_is_read, lat_is_read_nxt;
    logic [LW-1:0] lat_len, lat_len_nxt;

    logic [N-1:0]  req, pick, chosen;
    logic          accepted, is_read, beat, done_live;
    logic [LW-1:0] track_len;
    logic [CW:0]   beat_sum;

    function automatic logic [N-1:0] first_set(input logic [N-1:0] r);
        logic [N-1:0] g;
        g = '0;
        for (int i = 0; i < N; i++)
            if (r[i] && g == '0) g[i] = 1'b1;
        return g;
    endfunction

`ifdef ROUND_ROBIN_EN
    localparam int IW = $clog2(N);
    logic [IW-1:0] last_q, last_nxt;

    // Rotate requests so the search starts just after the last winner, encode, rotate back.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] last);
        logic [IW-1:0]  start;
        logic [2*N-1:0] dbl;
        logic [N-1:0]   g;
        start = (last == IW'(N - 1)) ? '0 : last + IW'(1);
        dbl   = {r, r} >> start;
        g     = first_set(dbl[N-1:0]);
        dbl   = {g, g} << start;
        return dbl[2*N-1:N];
    endfunction

    assign pick = rr_pick(req, last_q);
`else
    assign pick = first_set(req);
`endif

    assign req = in_rd | in_wr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant_q     <= '0;
            beat_cnt    <= '0;
            perr_q      <= 1'b0;
            lat_is_read <= 1'b0;
            lat_len     <= '0;
`ifdef ROUND_ROBIN_EN
            last_q      <= IW'(N - 1);
`endif
        end else begin
            state       <= state_nxt;
            grant_q     <= grant_nxt;
            beat_cnt    <= beat_cnt_nxt;
            perr_q      <= perr_nxt;
            lat_is_read <= lat_is_read_nxt;
            lat_len     <= lat_len_nxt;
`ifdef ROUND_ROBIN_EN
            last_q      <= last_nxt;
`endif
        end
    end

    always_comb begin
        accepted  = (state == IDLE) && (out_rd || out_wr) && out_wait_n;
        is_read   = (state == BUSY) ? lat_is_read : out_rd;
        beat      = (chosen != '0) && (is_read ? out_valid : (out_wr && out_wait_n));
        track_len = (state == BUSY) ? lat_len : out_burst_len;
        done_live = out_burst_done && ((state == BUSY) || accepted);
        beat_sum  = {1'b0, beat_cnt} + {{CW{1'b0}}, beat};

        state_nxt       = state;
        grant_nxt       = grant_q;
        lat_is_read_nxt = lat_is_read;
        lat_len_nxt     = lat_len;
        perr_nxt        = perr_q | (done_live && (beat_sum != {2'b00, track_len}));

        beat_cnt_nxt = beat_cnt;
        if (out_burst_done)
            beat_cnt_nxt = '0;
        else if (beat && beat_cnt != '1)
            beat_cnt_nxt = beat_cnt + CW'(1);

        if (state == IDLE) begin
            if (accepted) begin
                lat_is_read_nxt = out_rd;
                lat_len_nxt     = out_burst_len;
                // A burst completing in its own acceptance cycle never leaves IDLE.
                if (!out_burst_done) begin
                    state_nxt = BUSY;
                    grant_nxt = chosen;
                end
            end
        end else if (out_burst_done) begin
            state_nxt = IDLE;
            grant_nxt = '0;
        end

`ifdef ROUND_ROBIN_EN
        last_nxt = last_q;
        if (accepted)
            for (int i = 0; i < N; i++)
                if (chosen[i]) last_nxt = IW'(i);
`endif
    end

    always_comb begin
        // Reset forces the mux closed even while clients keep requesting.
        chosen        = ((state == BUSY) ? grant_q : pick) & {N{reset}};
        out_rd        = |(chosen & in_rd);
        out_wr        = |(chosen & in_wr & ~in_rd);
        out_addr      = '0;
        out_din       = '0;
        out_mask      = '0;
        out_burst_len = '0;
        for (int i = 0; i < N; i++) begin
            out_addr      = out_addr | (in_addr[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{chosen[i]}});
            out_din       = out_din | (in_din[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{chosen[i]}});
            out_mask      = out_mask | (in_mask[i*MW +: MW] & {MW{chosen[i]}});
            out_burst_len = out_burst_len | (in_burst_len[i*LW +: LW] & {LW{chosen[i]}});
        end
        if (chosen != '0 && out_burst_len == '0)
            out_burst_len = LW'(1);
        in_wait_n     = {N{out_wait_n}} & ((chosen == '0) ? {N{1'b1}} : chosen);
        in_valid      = chosen & {N{out_valid}};
        in_burst_done = chosen & {N{out_burst_done}};
    end

    assign in_dout        = out_dout;
    assign busy           = (state == BUSY);
    assign grant          = grant_q;
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_burst_mem_arbiter_n.sv
// Self-checking bench for burst_mem_arbiter_n: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_burst_mem_arbiter_n;
    localparam int N    = 3;
    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int BLW  = 8;
    localparam int MW   = DW / 8;
    localparam int CMAX = (1 << (BLW + 1)) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [N-1:0]     in_rd, in_wr;
    logic [N*AW-1:0]  in_addr;
    logic [N*DW-1:0]  in_din;
    logic [N*MW-1:0]  in_mask;
    logic [N*BLW-1:0] in_burst_len;
    logic [DW-1:0]    in_dout;
    logic [N-1:0]     in_wait_n, in_valid, in_burst_done;
    logic             out_rd, out_wr;
    logic [AW-1:0]    out_addr;
    logic [MW-1:0]    out_mask;
    logic [DW-1:0]    out_din;
    logic [BLW-1:0]   out_burst_len;
    logic [DW-1:0]    out_dout;
    logic             out_wait_n, out_valid, out_burst_done;
    logic             busy;
    logic [N-1:0]     grant;
    logic             protocol_error;

    logic [AW-1:0]  addr_a [N];
    logic [DW-1:0]  din_a  [N];
    logic [MW-1:0]  mask_a [N];
    logic [BLW-1:0] len_a  [N];

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model state: owner index (-1 when idle) and the burst being tracked.
    int m_owner, m_len, m_cnt, m_last;
    bit m_is_read, m_err;

    int          e_c, e_blen, e_len_now;
    bit          e_rd, e_wr, e_acc, e_rmode, e_beat;
    logic [N-1:0] e_wait;
    logic [DW-1:0] e_dout;
    int          rr_order [4];

    burst_mem_arbiter_n #(
        .NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN_WIDTH(BLW)
    ) dut (
        .clock(clock), .reset(reset),
        .in_rd(in_rd), .in_wr(in_wr), .in_addr(in_addr), .in_din(in_din),
        .in_mask(in_mask), .in_burst_len(in_burst_len), .in_dout(in_dout),
        .in_wait_n(in_wait_n), .in_valid(in_valid), .in_burst_done(in_burst_done),
        .out_rd(out_rd), .out_wr(out_wr), .out_addr(out_addr), .out_mask(out_mask),
        .out_din(out_din), .out_burst_len(out_burst_len), .out_dout(out_dout),
        .out_wait_n(out_wait_n), .out_valid(out_valid), .out_burst_done(out_burst_done),
        .busy(busy), .grant(grant), .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    always_comb begin
        in_addr      = '0;
        in_din       = '0;
        in_mask      = '0;
        in_burst_len = '0;
        for (int i = 0; i < N; i++) begin
            in_addr[i*AW +: AW]        = addr_a[i];
            in_din[i*DW +: DW]         = din_a[i];
            in_mask[i*MW +: MW]        = mask_a[i];
            in_burst_len[i*BLW +: BLW] = len_a[i];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        in_rd          = '0;
        in_wr          = '0;
        out_wait_n     = 1'b0;
        out_valid      = 1'b0;
        out_burst_done = 1'b0;
        out_dout       = '0;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = '0;
            din_a[i]  = '0;
            mask_a[i] = '0;
            len_a[i]  = '0;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_len     = 0;
        m_cnt     = 0;
        m_last    = N - 1;
        m_is_read = 1'b0;
        m_err     = 1'b0;
    endtask

    function automatic int m_pick();
        if (m_owner >= 0) return m_owner;
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (in_rd[idx] || in_wr[idx]) return idx;
        end
`else
        for (int i = 0; i < N; i++)
            if (in_rd[i] || in_wr[i]) return i;
`endif
        return -1;
    endfunction

    task automatic random_inputs();
        for (int i = 0; i < N; i++) begin
            in_rd[i]  = ($urandom_range(0, 99) < 30);
            in_wr[i]  = ($urandom_range(0, 99) < 35);
            addr_a[i] = $urandom;
            din_a[i]  = {$urandom, $urandom};
            mask_a[i] = MW'($urandom);
            len_a[i]  = ($urandom_range(0, 9) == 0) ? BLW'($urandom) : BLW'($urandom_range(0, 4));
        end
        out_wait_n = ($urandom_range(0, 99) < 75);
        out_dout   = {$urandom, $urandom};
        if (m_owner >= 0) begin
            out_valid      = (m_cnt < m_len) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 5);
            out_burst_done = (m_cnt >= m_len) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 4);
        end else begin
            out_valid      = 1'b0;
            out_burst_done = 1'b0;
        end
    endtask

    task automatic model_check_and_step();
        e_c    = m_pick();
        e_rd   = (e_c >= 0) && in_rd[e_c];
        e_wr   = (e_c >= 0) && in_wr[e_c] && !in_rd[e_c];
        e_blen = (e_c < 0) ? 0 : ((len_a[e_c] == 0) ? 1 : int'(len_a[e_c]));
        for (int i = 0; i < N; i++) e_wait[i] = out_wait_n && (e_c < 0 || e_c == i);
        e_dout = out_dout;

        check("r_out_rd", out_rd, e_rd);
        check("r_out_wr", out_wr, e_wr);
        check("r_out_addr", out_addr, (e_c >= 0) ? addr_a[e_c] : '0);
        check("r_out_din", out_din, (e_c >= 0) ? din_a[e_c] : '0);
        check("r_out_mask", out_mask, (e_c >= 0) ? mask_a[e_c] : '0);
        check("r_out_blen", out_burst_len, e_blen);
        check("r_in_wait_n", in_wait_n, e_wait);
        check("r_in_valid", in_valid, (e_c >= 0 && out_valid) ? (64'd1 << e_c) : 64'd0);
        check("r_in_bdone", in_burst_done, (e_c >= 0 && out_burst_done) ? (64'd1 << e_c) : 64'd0);
        check("r_in_dout", in_dout, e_dout);
        check("r_grant", grant, (m_owner >= 0) ? (64'd1 << m_owner) : 64'd0);
        check("r_busy", busy, m_owner >= 0);
        check("r_perr", protocol_error, m_err);

        e_acc     = (m_owner < 0) && (e_rd || e_wr) && out_wait_n;
        e_rmode   = (m_owner >= 0) ? m_is_read : e_rd;
        e_beat    = (e_c >= 0) && (e_rmode ? out_valid : (e_wr && out_wait_n));
        e_len_now = (m_owner >= 0) ? m_len : e_blen;
        if (out_burst_done && (m_owner >= 0 || e_acc) && (m_cnt + int'(e_beat) != e_len_now))
            m_err = 1'b1;
        if (out_burst_done) m_cnt = 0;
        else if (e_beat && m_cnt < CMAX) m_cnt++;
        if (e_acc) begin
            m_is_read = e_rd;
            m_len     = e_blen;
            m_last    = e_c;
        end
        if (m_owner >= 0) begin
            if (out_burst_done) m_owner = -1;
        end else if (e_acc && !out_burst_done) begin
            m_owner = e_c;
        end
    endtask

    initial begin
        clear_inputs();
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", protocol_error, 0);
        check("rst_out_rd", out_rd, 0);
        reset = 1'b1;

        // Single read burst on channel 0
        in_rd[0] = 1'b1; addr_a[0] = 32'h1000; len_a[0] = 8'd16; out_wait_n = 1'b1;
        settle();
        check("t1_out_rd", out_rd, 1);
        check("t1_out_addr", out_addr, 32'h1000);
        check("t1_out_blen", out_burst_len, 16);
        check("t1_in_wait_n", in_wait_n, 3'b001);
        check("t1_busy_pre", busy, 0);
        tick();
        in_rd[0] = 1'b0;
        settle();
        check("t1_busy", busy, 1);
        check("t1_grant", grant, 3'b001);
        for (int b = 0; b < 16; b++) begin
            e_dout = {$urandom, $urandom};
            out_valid = 1'b1; out_dout = e_dout;
            settle();
            check("t1_in_valid", in_valid, 3'b001);
            check("t1_in_dout", in_dout, e_dout);
            tick();
        end
        out_valid = 1'b0; out_burst_done = 1'b1;
        settle();
        check("t1_in_bdone", in_burst_done, 3'b001);
        tick();
        out_burst_done = 1'b0;
        settle();
        check("t1_busy_end", busy, 0);
        check("t1_grant_end", grant, 0);
        check("t1_perr", protocol_error, 0);

        // Priority and grant hold: ch1 and ch2 write together
        clear_inputs(); pulse_reset();
        in_wr[1] = 1'b1; in_wr[2] = 1'b1; mask_a[1] = 8'hF0; mask_a[2] = 8'h0F;
        len_a[1] = 8'd2; len_a[2] = 8'd1; addr_a[1] = 32'hA0; addr_a[2] = 32'hB0; out_wait_n = 1'b1;
        settle();
        check("t2_out_wr", out_wr, 1);
        check("t2_out_mask1", out_mask, 8'hF0);
        check("t2_in_wait_n", in_wait_n, 3'b010);
        tick(); settle();
        check("t2_grant", grant, 3'b010);
        check("t2_hold_wait", in_wait_n, 3'b010);
        tick();
        in_wr[1] = 1'b0; out_burst_done = 1'b1;
        settle();
        check("t2_hold_wait2", in_wait_n, 3'b010);
        check("t2_in_bdone", in_burst_done, 3'b010);
        tick();
        out_burst_done = 1'b0;
        settle();
        check("t2_idle_grant", grant, 0);
        check("t2_out_mask2", out_mask, 8'h0F);
        check("t2_out_addr2", out_addr, 32'hB0);
        check("t2_in_wait_n2", in_wait_n, 3'b100);
        tick(); settle();
        check("t2_grant2", grant, 3'b100);
        in_wr[2] = 1'b0; out_burst_done = 1'b1;
        settle(); tick();
        out_burst_done = 1'b0;
        settle();
        check("t2_busy_end", busy, 0);
        check("t2_perr", protocol_error, 0);

        // Spurious completion, then stall with zero length
        clear_inputs(); pulse_reset();
        out_burst_done = 1'b1;
        settle(); tick();
        out_burst_done = 1'b0;
        settle();
        check("t3_spur_perr", protocol_error, 0);
        check("t3_spur_busy", busy, 0);
        in_rd[0] = 1'b1; len_a[0] = 8'd0; out_wait_n = 1'b0;
        for (int s = 0; s < 5; s++) begin
            settle();
            check("t3_stall_grant", grant, 0);
            check("t3_stall_busy", busy, 0);
            check("t3_stall_out_rd", out_rd, 1);
            check("t3_stall_wait_n", in_wait_n, 3'b000);
            tick();
        end
        out_wait_n = 1'b1;
        settle();
        check("t3_len0_blen", out_burst_len, 1);
        tick(); settle();
        check("t3_grant", grant, 3'b001);
        check("t3_busy", busy, 1);
        in_rd[0] = 1'b0; out_valid = 1'b1; out_burst_done = 1'b1;
        settle(); tick();
        out_valid = 1'b0; out_burst_done = 1'b0;
        settle();
        check("t3_busy_end", busy, 0);
        check("t3_perr", protocol_error, 0);

        // Beat-count mismatch, then a clean burst
        clear_inputs(); pulse_reset();
        in_rd[0] = 1'b1; len_a[0] = 8'd8; out_wait_n = 1'b1;
        settle(); tick();
        in_rd[0] = 1'b0;
        for (int b = 0; b < 7; b++) begin
            out_valid = 1'b1;
            settle(); tick();
        end
        out_valid = 1'b0; out_burst_done = 1'b1;
        settle();
        check("t4_perr_pre", protocol_error, 0);
        tick();
        out_burst_done = 1'b0;
        settle();
        check("t4_perr", protocol_error, 1);
        check("t4_busy", busy, 0);
        in_wr[1] = 1'b1; len_a[1] = 8'd1;
        settle(); tick(); settle();
        check("t4_grant_clean", grant, 3'b010);
        in_wr[1] = 1'b0; out_burst_done = 1'b1;
        settle(); tick();
        out_burst_done = 1'b0;
        settle();
        check("t4_busy_clean", busy, 0);
        check("t4_perr_held", protocol_error, 1);

        // Asynchronous reset in the middle of a burst
        clear_inputs(); pulse_reset();
        in_rd[0] = 1'b1; len_a[0] = 8'd4; out_wait_n = 1'b1;
        settle(); tick(); settle();
        check("t5_busy_pre", busy, 1);
        check("t5_out_rd_pre", out_rd, 1);
        #1 reset = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_grant", grant, 0);
        check("t5_out_rd", out_rd, 0);
        check("t5_out_addr", out_addr, 0);
        reset = 1'b1;

`ifdef ROUND_ROBIN_EN
        // Rotating priority with all channels requesting continuously
        clear_inputs(); pulse_reset();
        in_rd = '1; len_a[0] = 8'd1; len_a[1] = 8'd1; len_a[2] = 8'd1; out_wait_n = 1'b1;
        rr_order = '{0, 1, 2, 0};
        for (int k = 0; k < 4; k++) begin
            settle(); tick(); settle();
            check("rr_grant", grant, 64'd1 << rr_order[k]);
            out_valid = 1'b1; out_burst_done = 1'b1;
            settle(); tick();
            out_valid = 1'b0; out_burst_done = 1'b0;
        end
`endif

        // Randomized traffic against the behavioural model, reset between segments
        for (int seg = 0; seg < 40; seg++) begin
            clear_inputs(); pulse_reset(); model_reset();
            for (int cyc = 0; cyc < 50; cyc++) begin
                random_inputs();
                settle();
                model_check_and_step();
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
